// File: rtl/nl2_scrub_pkg.sv
// Shared types for the dbank scrub scheduler: FSM state encoding and the scrub work item.
`ifndef nl2_SRAM_BLOCK_ADDR_SIZE
`define nl2_SRAM_BLOCK_ADDR_SIZE 10
`endif

package nl2_scrub_pkg;

    // Widest bank select / block address an item can carry; narrower instances zero-pad.
    localparam int SCRUB_MAX_SRAM   = 4;
    localparam int SCRUB_MAX_ADDR_W = `nl2_SRAM_BLOCK_ADDR_SIZE;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        RD,
        RDW,
        SCR
    } scrub_sched_state_e;

    typedef struct packed {
        logic [SCRUB_MAX_SRAM-1:0]   bnk;
        logic [SCRUB_MAX_ADDR_W-1:0] addr;
        logic                        is_err;
    } scrub_item_t;

    function automatic scrub_item_t mk_item(input logic [SCRUB_MAX_SRAM-1:0]   bnk,
                                            input logic [SCRUB_MAX_ADDR_W-1:0] addr,
                                            input logic                        is_err);
        scrub_item_t it;
        it.bnk    = bnk;
        it.addr   = addr;
        it.is_err = is_err;
        return it;
    endfunction

endpackage

// File: rtl/nl2_dbank_scrub_sched_if.sv
// Handshake bundle between the scrub scheduler (master) and ECC/read/scrub-control logic (slave).
interface nl2_dbank_scrub_sched_if #(
    parameter int N_SRAM          = 4,
    parameter int BLOCK_ADDR_SIZE = `nl2_SRAM_BLOCK_ADDR_SIZE,
    parameter int INTERVAL_W      = 16
);
    logic                       patrol_en;
    logic [INTERVAL_W-1:0]      patrol_intvl;

    logic                       err_valid;
    logic                       err_ready;
    logic [N_SRAM-1:0]          err_bnk;
    logic [BLOCK_ADDR_SIZE-1:0] err_addr;

    logic                       rd_req;
    logic                       rd_ack;
    logic [N_SRAM-1:0]          rd_bnk;
    logic [BLOCK_ADDR_SIZE-1:0] rd_addr;
    logic                       rd_done;

    logic                       req_scrub;
    logic                       req_ack;
    logic [N_SRAM-1:0]          req_bnk;
    logic [BLOCK_ADDR_SIZE-1:0] req_addr;

    logic                       sched_busy;
    logic                       sweep_done;

    modport master (
        input  patrol_en, patrol_intvl, err_valid, err_bnk, err_addr, rd_ack, rd_done, req_ack,
        output err_ready, rd_req, rd_bnk, rd_addr, req_scrub, req_bnk, req_addr, sched_busy, sweep_done
    );

    modport slave (
        output patrol_en, patrol_intvl, err_valid, err_bnk, err_addr, rd_ack, rd_done, req_ack,
        input  err_ready, rd_req, rd_bnk, rd_addr, req_scrub, req_bnk, req_addr, sched_busy, sweep_done
    );
endinterface

// File: rtl/nl2_scrub_patrol_ptr.sv
// Patrol pointer: walks block addresses of one bank, then rotates to the next bank (one-hot).
module nl2_scrub_patrol_ptr #(
    parameter int N_SRAM = 4,
    parameter int ADDR_W = `nl2_SRAM_BLOCK_ADDR_SIZE
) (
    input  logic              clk,
    input  logic              rst_a,
    input  logic              adv_i,
    output logic [N_SRAM-1:0] bnk_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              sweep_done_o
);
    logic [N_SRAM-1:0] bnk_q, bnk_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              sweep_q, sweep_d;
    logic              addr_wrap;

    assign addr_wrap = &addr_q;

    always_comb begin
        bnk_d   = bnk_q;
        addr_d  = addr_q;
        sweep_d = adv_i & addr_wrap & bnk_q[N_SRAM-1];
        if (adv_i) begin
            addr_d = addr_q + 1'b1;
            if (addr_wrap) bnk_d = {bnk_q[N_SRAM-2:0], bnk_q[N_SRAM-1]};
        end
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            bnk_q   <= N_SRAM'(1);
            addr_q  <= '0;
            sweep_q <= 1'b0;
        end else begin
            bnk_q   <= bnk_d;
            addr_q  <= addr_d;
            sweep_q <= sweep_d;
        end
    end

    assign bnk_o        = bnk_q;
    assign addr_o       = addr_q;
    assign sweep_done_o = sweep_q;
endmodule

// File: rtl/nl2_dbank_scrub_sched.sv
// Scrub scheduler: arbitrates held ECC-error items over timed patrol items, then sequences
// corrected-read and scrub-control handshakes for one item at a time.
module nl2_dbank_scrub_sched
    import nl2_scrub_pkg::*;
#(
    parameter int N_SRAM          = 4,
    parameter int BLOCK_ADDR_SIZE = `nl2_SRAM_BLOCK_ADDR_SIZE,
    parameter int INTERVAL_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst_a,
    nl2_dbank_scrub_sched_if.master sched_if
);
    scrub_sched_state_e         state_q, state_d;
    scrub_item_t                cur_q, cur_d;
    logic                       hold_q, hold_d;
    logic [N_SRAM-1:0]          err_bnk_q;
    logic [BLOCK_ADDR_SIZE-1:0] err_addr_q;
    logic                       err_ready_q;
    logic [INTERVAL_W-1:0]      intvl_cnt_q, intvl_cnt_d;
    logic                       rd_req_q, req_scrub_q;
    logic                       err_cap, ptr_adv, next_sel;
    logic [N_SRAM-1:0]          ptr_bnk;
    logic [BLOCK_ADDR_SIZE-1:0] ptr_addr;

    assign err_cap = sched_if.err_valid & err_ready_q;

    nl2_scrub_patrol_ptr #(
        .N_SRAM (N_SRAM),
        .ADDR_W (BLOCK_ADDR_SIZE)
    ) u_ptr (
        .clk          (clk),
        .rst_a        (rst_a),
        .adv_i        (ptr_adv),
        .bnk_o        (ptr_bnk),
        .addr_o       (ptr_addr),
        .sweep_done_o (sched_if.sweep_done)
    );

    // The counter holds the number of idle cycles still owed, so the last idle cycle
    // (count 1) already selects; an interval of 0 chains straight from SCR into SEL.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        hold_d      = hold_q;
        intvl_cnt_d = intvl_cnt_q;
        ptr_adv     = 1'b0;
        next_sel    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (intvl_cnt_q != '0) intvl_cnt_d = intvl_cnt_q - 1'b1;
                if (hold_q || (sched_if.patrol_en && intvl_cnt_q[INTERVAL_W-1:1] == '0))
                    state_d = SEL;
            end
            SEL: begin
                cur_d   = hold_q ? mk_item(SCRUB_MAX_SRAM'(err_bnk_q), SCRUB_MAX_ADDR_W'(err_addr_q), 1'b1)
                                 : mk_item(SCRUB_MAX_SRAM'(ptr_bnk), SCRUB_MAX_ADDR_W'(ptr_addr), 1'b0);
                state_d = RD;
            end
            RD:  if (sched_if.rd_ack)  state_d = RDW;
            RDW: if (sched_if.rd_done) state_d = SCR;
            SCR: begin
                if (sched_if.req_ack) begin
                    if (cur_q.is_err) begin
                        hold_d   = 1'b0;
                        next_sel = sched_if.patrol_en && intvl_cnt_q == '0;
                    end else begin
                        ptr_adv     = 1'b1;
                        intvl_cnt_d = sched_if.patrol_intvl;
                        next_sel    = hold_q || (sched_if.patrol_en && sched_if.patrol_intvl == '0);
                    end
                    state_d = next_sel ? SEL : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (err_cap) hold_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            hold_q      <= 1'b0;
            err_bnk_q   <= '0;
            err_addr_q  <= '0;
            err_ready_q <= 1'b0;
            intvl_cnt_q <= '0;
            rd_req_q    <= 1'b0;
            req_scrub_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            hold_q      <= hold_d;
            err_ready_q <= ~hold_d;
            intvl_cnt_q <= intvl_cnt_d;
            rd_req_q    <= (state_d == RD);
            req_scrub_q <= (state_d == SCR);
            if (err_cap) begin
                err_bnk_q  <= sched_if.err_bnk;
                err_addr_q <= sched_if.err_addr;
            end
        end
    end

    assign sched_if.err_ready  = err_ready_q;
    assign sched_if.rd_req     = rd_req_q;
    assign sched_if.rd_bnk     = cur_q.bnk[N_SRAM-1:0];
    assign sched_if.rd_addr    = cur_q.addr[BLOCK_ADDR_SIZE-1:0];
    assign sched_if.req_scrub  = req_scrub_q;
    assign sched_if.req_bnk    = cur_q.bnk[N_SRAM-1:0];
    assign sched_if.req_addr   = cur_q.addr[BLOCK_ADDR_SIZE-1:0];
    assign sched_if.sched_busy = (state_q != IDLE);

    // Items narrower than the package maximum keep their padding bits at zero.
    if (N_SRAM < SCRUB_MAX_SRAM) begin : g_bnk_pad
        a_bnk_pad: assert property (@(posedge clk) disable iff (rst_a)
            cur_q.bnk[SCRUB_MAX_SRAM-1:N_SRAM] == '0);
    end
    if (BLOCK_ADDR_SIZE < SCRUB_MAX_ADDR_W) begin : g_addr_pad
        a_addr_pad: assert property (@(posedge clk) disable iff (rst_a)
            cur_q.addr[SCRUB_MAX_ADDR_W-1:BLOCK_ADDR_SIZE] == '0);
    end
endmodule

// File: tb/tb_nl2_dbank_scrub_sched.sv
// Directed bench for nl2_dbank_scrub_sched: patrol sweep table plus multi-cycle corner sequences.
module tb_nl2_dbank_scrub_sched;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    nl2_dbank_scrub_sched_if #(.N_SRAM(4), .BLOCK_ADDR_SIZE(2), .INTERVAL_W(16)) bus ();

    nl2_dbank_scrub_sched #(.N_SRAM(4), .BLOCK_ADDR_SIZE(2), .INTERVAL_W(16)) dut (
        .clk      (clk),
        .rst_a    (rst_a),
        .sched_if (bus)
    );

    typedef struct {
        logic [3:0] bnk;
        logic [1:0] addr;
        int         rdly;
        int         adly;
        logic       sweep;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_rd(input string nm);
        int n = 0;
        while (bus.rd_req !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        chk({nm, "_rd_req_seen"}, {31'd0, bus.rd_req}, 1);
    endtask

    task automatic wait_scr(input string nm);
        int n = 0;
        while (bus.req_scrub !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        chk({nm, "_req_scrub_seen"}, {31'd0, bus.req_scrub}, 1);
    endtask

    task automatic rd_phase(input string nm, input logic [3:0] eb, input logic [1:0] ea, input int rdly);
        wait_rd(nm);
        for (int i = 0; i <= rdly; i++) begin
            chk({nm, "_rd_req_hold"}, {31'd0, bus.rd_req}, 1);
            chk({nm, "_rd_bnk"}, {28'd0, bus.rd_bnk}, {28'd0, eb});
            chk({nm, "_rd_addr"}, {30'd0, bus.rd_addr}, {30'd0, ea});
            if (i < rdly) @(negedge clk);
        end
        bus.rd_ack = 1'b1;
        @(negedge clk);
        bus.rd_ack = 1'b0;
        chk({nm, "_rd_req_drop"}, {31'd0, bus.rd_req}, 0);
    endtask

    task automatic scr_phase(input string nm, input logic [3:0] eb, input logic [1:0] ea, input int adly);
        wait_scr(nm);
        for (int i = 0; i <= adly; i++) begin
            chk({nm, "_req_hold"}, {31'd0, bus.req_scrub}, 1);
            chk({nm, "_req_bnk"}, {28'd0, bus.req_bnk}, {28'd0, eb});
            chk({nm, "_req_addr"}, {30'd0, bus.req_addr}, {30'd0, ea});
            if (i < adly) @(negedge clk);
        end
        bus.req_ack = 1'b1;
        @(negedge clk);
        bus.req_ack = 1'b0;
    endtask

    task automatic serve(input string nm, input logic [3:0] eb, input logic [1:0] ea, input int rdly, input int adly);
        rd_phase(nm, eb, ea, rdly);
        bus.rd_done = 1'b1;
        @(negedge clk);
        bus.rd_done = 1'b0;
        scr_phase(nm, eb, ea, adly);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_outs"}, {22'd0, bus.err_ready, bus.rd_req, bus.rd_bnk, bus.rd_addr, bus.req_scrub,
                            bus.req_bnk, bus.req_addr, bus.sched_busy, bus.sweep_done}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tbl[0]  = '{4'b0001, 2'd0, 0, 0, 1'b0};
        tbl[1]  = '{4'b0001, 2'd1, 0, 0, 1'b0};
        tbl[2]  = '{4'b0001, 2'd2, 0, 0, 1'b0};
        tbl[3]  = '{4'b0001, 2'd3, 0, 0, 1'b0};
        tbl[4]  = '{4'b0010, 2'd0, 0, 0, 1'b0};
        tbl[5]  = '{4'b0010, 2'd1, 3, 4, 1'b0};
        tbl[6]  = '{4'b0010, 2'd2, 0, 0, 1'b0};
        tbl[7]  = '{4'b0010, 2'd3, 0, 0, 1'b0};
        tbl[8]  = '{4'b0100, 2'd0, 0, 0, 1'b0};
        tbl[9]  = '{4'b0100, 2'd1, 1, 2, 1'b0};
        tbl[10] = '{4'b0100, 2'd2, 0, 0, 1'b0};
        tbl[11] = '{4'b0100, 2'd3, 0, 0, 1'b0};
        tbl[12] = '{4'b1000, 2'd0, 0, 0, 1'b0};
        tbl[13] = '{4'b1000, 2'd1, 0, 0, 1'b0};
        tbl[14] = '{4'b1000, 2'd2, 0, 0, 1'b0};
        tbl[15] = '{4'b1000, 2'd3, 0, 0, 1'b1};

        bus.patrol_en = 1'b0; bus.patrol_intvl = '0;
        bus.err_valid = 1'b0; bus.err_bnk = '0; bus.err_addr = '0;
        bus.rd_ack = 1'b0; bus.rd_done = 1'b0; bus.req_ack = 1'b0;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_a = 1'b0;
        @(negedge clk);
        chk("idle_err_ready", {31'd0, bus.err_ready}, 1);
        chk("idle_busy", {31'd0, bus.sched_busy}, 0);

        // full patrol sweep, back-to-back
        bus.patrol_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            serve($sformatf("sweep%0d", i), tbl[i].bnk, tbl[i].addr, tbl[i].rdly, tbl[i].adly);
            chk($sformatf("sweep%0d_done", i), {31'd0, bus.sweep_done}, {31'd0, tbl[i].sweep});
            chk($sformatf("sweep%0d_busy", i), {31'd0, bus.sched_busy}, 1);
        end
        @(negedge clk);
        chk("sweep_done_pulse", {31'd0, bus.sweep_done}, 0);

        // interval of 5 idle cycles
        bus.patrol_intvl = 16'd5;
        serve("intvl5", 4'b0001, 2'd0, 0, 0);
        n = 0;
        while (bus.sched_busy !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        chk("intvl5_idle_cycles", n, 5);
        bus.patrol_intvl = 16'd0;
        serve("intvl0", 4'b0001, 2'd1, 0, 0);
        chk("intvl0_busy", {31'd0, bus.sched_busy}, 1);

        // error request arrives while patrol item waits for read data
        rd_phase("errp", 4'b0001, 2'd2, 0);
        chk("err_ready_before", {31'd0, bus.err_ready}, 1);
        bus.err_valid = 1'b1; bus.err_bnk = 4'b0100; bus.err_addr = 2'd2;
        @(negedge clk);
        bus.err_valid = 1'b0;
        chk("err_ready_drop", {31'd0, bus.err_ready}, 0);
        bus.rd_done = 1'b1;
        @(negedge clk);
        bus.rd_done = 1'b0;
        scr_phase("errp", 4'b0001, 2'd2, 0);
        serve("erritem", 4'b0100, 2'd2, 0, 0);
        chk("err_ready_back", {31'd0, bus.err_ready}, 1);
        serve("resume", 4'b0001, 2'd3, 0, 0);

        // patrol disabled while the scrub request is outstanding
        rd_phase("pdis", 4'b0010, 2'd0, 0);
        bus.rd_done = 1'b1;
        @(negedge clk);
        bus.rd_done = 1'b0;
        wait_scr("pdis");
        bus.patrol_en = 1'b0;
        @(negedge clk);
        scr_phase("pdis", 4'b0010, 2'd0, 0);
        chk("pdis_busy", {31'd0, bus.sched_busy}, 0);
        repeat (4) @(negedge clk);
        chk("pdis_parked_busy", {31'd0, bus.sched_busy}, 0);
        chk("pdis_parked_rd", {31'd0, bus.rd_req}, 0);
        bus.patrol_en = 1'b1;
        serve("reen", 4'b0010, 2'd1, 0, 0);

        // reset while waiting for read data, with an error held
        wait_rd("rst");
        chk("rst_rd_addr", {30'd0, bus.rd_addr}, 2);
        bus.rd_ack = 1'b1;
        bus.err_valid = 1'b1; bus.err_bnk = 4'b1000; bus.err_addr = 2'd1;
        @(negedge clk);
        bus.rd_ack = 1'b0; bus.err_valid = 1'b0;
        chk("rst_err_held", {31'd0, bus.err_ready}, 0);
        rst_a = 1'b1;
        #1;
        chk_all_zero("rst_async");
        @(negedge clk);
        chk_all_zero("rst_held");
        rst_a = 1'b0;
        @(negedge clk);
        chk("rst_err_ready", {31'd0, bus.err_ready}, 1);
        serve("post_rst", 4'b0001, 2'd0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
